scan_digit_entry: RTL and testbench
===================================

// Module: scan_digit_entry
// PURPOSE
//   Sequential successor to the combinational scan-to-digit decoder. Consumes the
//   PS/2 set-2 byte stream from the keyboard receiver and decodes make codes for
//   digit keys, including optional numpad keys. Accumulates up to NUM_DIGITS
//   decimal digits into a BCD entry buffer and supports Backspace, Esc and Enter.
//   Sits between the PS/2 receiver and the code-check / display logic.
// PARAMETERS
//   NUM_DIGITS  4  max digits held in entry buffer (1..8)
//   NUMPAD_EN   1  1: numpad digit codes (70,69,72,7A,6B,73,74,6C,75,7D) also accepted
//   CNT_W       4  width of digit_count; must hold NUM_DIGITS
// PORTS
//   clk          in   1             system clock, all logic on rising edge
//   rst_n        in   1             asynchronous reset, active low
//   scan_code    in   8             byte from PS/2 receiver
//   scan_valid   in   1             1-cycle strobe: scan_code is new
//   entry_bcd    out  4*NUM_DIGITS  live buffer; digit 0 (newest) in [3:0], unused = 0
//   digit_count  out  CNT_W         digits currently held (0..NUM_DIGITS)
//   digit_stb    out  1             1-cycle pulse: a digit was accepted
//   digit_val    out  4             value of last accepted digit (held between strobes)
//   commit_stb   out  1             1-cycle pulse: Enter with digit_count>0
//   commit_bcd   out  4*NUM_DIGITS  buffer snapshot taken on commit, held until next commit
//   commit_len   out  CNT_W         digit_count at commit
//   key_error    out  1             1-cycle pulse: rejected make code (see below)
// BEHAVIOUR
//   - Reset (rst_n=0, async): all outputs 0, FSM in S_MAKE, buffer empty.
//   - Bytes are processed only on cycles with scan_valid=1. Every output updates on
//     the clock edge that samples the byte (registered, 1-cycle latency). Strobes
//     last exactly one cycle.
//   - FSM states:
//       S_MAKE: F0 -> S_BRK; E0 -> S_EXT; other byte -> decode as make code.
//       S_EXT:  F0 -> S_BRK; 5A -> Enter (keypad Enter) -> S_MAKE;
//               other byte -> ignored -> S_MAKE.
//       S_BRK:  any byte -> discarded (key release) -> S_MAKE.
//     E0,F0,xx is therefore a full release. Typematic repeats of a make code are
//     processed as new keypresses.
//   - Make-code decode in S_MAKE:
//       digit (45,16,1E,26,25,2E,36,3D,3E,46 = 0..9; numpad set if NUMPAD_EN):
//         if count<NUM_DIGITS: entry_bcd <= {entry_bcd<<4} | d, count+1,
//         digit_stb=1, digit_val=d.
//         If count==NUM_DIGITS: buffer unchanged and key_error=1.
//       66 Backspace: if count>0: entry_bcd >>= 4 (zero fill), count-1.
//         If count==0: no effect and no error.
//       76 Esc: buffer and count cleared; no error.
//       5A Enter: if count>0: commit_bcd<=entry_bcd, commit_len<=count,
//         commit_stb=1, buffer and count cleared. If count==0: ignored.
//       any other code: key_error=1, buffer unchanged.
//   - Bits above 4*count in entry_bcd are always 0.
//   - scan_valid held high on consecutive cycles: each cycle is a separate byte.
//   - Reset asserted mid-sequence (e.g. after F0) returns to S_MAKE. The next byte
//     is then treated as a make code.
// TESTING
//   1. Reset, bytes 16,1E,26 -> entry_bcd=0x123, count=3, three digit_stb (vals 1,2,3)
//   2. 16,1E,26,25,2E (NUM_DIGITS=4) -> count=4, entry_bcd=0x1234, key_error on 5th
//   3. 16,F0,16,1E -> release discarded; entry_bcd=0x12, count=2, no key_error
//   4. 36,3D,66,5A -> commit_stb once, commit_bcd=0x6, commit_len=1, count=0 after
//   5. 5A with empty buffer -> no commit_stb; then 3E,E0,5A -> commit_bcd=0x8
//   6. 1C (not digit) -> key_error pulse; rst_n low after F0, then 45 -> digit 0 accepted

Source files
------------

// File: rtl/scan_digit_entry.sv
// PS/2 set-2 make-code digit entry: BCD buffer with Backspace/Esc/Enter commit.
// Latency 1 cycle from scan_valid_i to all outputs; no backpressure, every valid byte is consumed.
module scan_digit_entry #(
  parameter int NUM_DIGITS = 4,
  parameter int NUMPAD_EN  = 1,
  parameter int CNT_W      = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [7:0]              scan_code_i,
  input  logic                    scan_valid_i,
  output logic [4*NUM_DIGITS-1:0] entry_bcd_o,
  output logic [CNT_W-1:0]        digit_count_o,
  output logic                    digit_stb_o,
  output logic [3:0]              digit_val_o,
  output logic                    commit_stb_o,
  output logic [4*NUM_DIGITS-1:0] commit_bcd_o,
  output logic [CNT_W-1:0]        commit_len_o,
  output logic                    key_error_o
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_DIGITS);

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_BKSP  = 8'h66;
  localparam logic [7:0] CODE_ESC   = 8'h76;
  localparam logic [7:0] CODE_ENTER = 8'h5A;

  typedef enum logic [1:0] {
    S_MAKE = 2'd0,
    S_EXT  = 2'd1,
    S_BRK  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         entry_q, entry_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  digit_stb_q, digit_stb_d;
  logic [3:0]            digit_val_q, digit_val_d;
  logic                  commit_stb_q, commit_stb_d;
  logic [BW-1:0]         commit_bcd_q, commit_bcd_d;
  logic [CNT_W-1:0]      commit_len_q, commit_len_d;
  logic                  key_error_q, key_error_d;

  // Returns {hit, value}; numpad codes only hit when NUMPAD_EN is set.
  function automatic logic [4:0] decode_digit(input logic [7:0] code);
    logic [4:0] res;
    res = 5'b0_0000;
    case (code)
      8'h45: res = 5'b1_0000;
      8'h16: res = 5'b1_0001;
      8'h1E: res = 5'b1_0010;
      8'h26: res = 5'b1_0011;
      8'h25: res = 5'b1_0100;
      8'h2E: res = 5'b1_0101;
      8'h36: res = 5'b1_0110;
      8'h3D: res = 5'b1_0111;
      8'h3E: res = 5'b1_1000;
      8'h46: res = 5'b1_1001;
      default: res = 5'b0_0000;
    endcase
    if (NUMPAD_EN != 0) begin
      case (code)
        8'h70: res = 5'b1_0000;
        8'h69: res = 5'b1_0001;
        8'h72: res = 5'b1_0010;
        8'h7A: res = 5'b1_0011;
        8'h6B: res = 5'b1_0100;
        8'h73: res = 5'b1_0101;
        8'h74: res = 5'b1_0110;
        8'h6C: res = 5'b1_0111;
        8'h75: res = 5'b1_1000;
        8'h7D: res = 5'b1_1001;
        default: ;
      endcase
    end
    return res;
  endfunction

  logic [4:0] dig;
  logic       do_enter;

  assign dig = decode_digit(scan_code_i);

  always_comb begin
    state_d      = state_q;
    entry_d      = entry_q;
    count_d      = count_q;
    digit_stb_d  = 1'b0;
    digit_val_d  = digit_val_q;
    commit_stb_d = 1'b0;
    commit_bcd_d = commit_bcd_q;
    commit_len_d = commit_len_q;
    key_error_d  = 1'b0;
    do_enter     = 1'b0;

    if (scan_valid_i) begin
      case (state_q)
        S_MAKE: begin
          if (scan_code_i == CODE_BRK) begin
            state_d = S_BRK;
          end else if (scan_code_i == CODE_EXT) begin
            state_d = S_EXT;
          end else if (dig[4]) begin
            if (count_q < MAX_CNT) begin
              // Upper nibble is guaranteed zero here, so the shift loses nothing.
              entry_d     = (entry_q << 4) | BW'(dig[3:0]);
              count_d     = count_q + CNT_W'(1);
              digit_stb_d = 1'b1;
              digit_val_d = dig[3:0];
            end else begin
              key_error_d = 1'b1;
            end
          end else if (scan_code_i == CODE_BKSP) begin
            if (count_q != '0) begin
              entry_d = entry_q >> 4;
              count_d = count_q - CNT_W'(1);
            end
          end else if (scan_code_i == CODE_ESC) begin
            entry_d = '0;
            count_d = '0;
          end else if (scan_code_i == CODE_ENTER) begin
            do_enter = 1'b1;
          end else begin
            key_error_d = 1'b1;
          end
        end
        S_EXT: begin
          if (scan_code_i == CODE_BRK) begin
            state_d = S_BRK;
          end else begin
            state_d  = S_MAKE;
            do_enter = (scan_code_i == CODE_ENTER);
          end
        end
        S_BRK: begin
          state_d = S_MAKE;
        end
        default: begin
          state_d = S_MAKE;
        end
      endcase

      if (do_enter && (count_q != '0)) begin
        commit_bcd_d = entry_q;
        commit_len_d = count_q;
        commit_stb_d = 1'b1;
        entry_d      = '0;
        count_d      = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_MAKE;
      entry_q      <= '0;
      count_q      <= '0;
      digit_stb_q  <= 1'b0;
      digit_val_q  <= 4'h0;
      commit_stb_q <= 1'b0;
      commit_bcd_q <= '0;
      commit_len_q <= '0;
      key_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      entry_q      <= entry_d;
      count_q      <= count_d;
      digit_stb_q  <= digit_stb_d;
      digit_val_q  <= digit_val_d;
      commit_stb_q <= commit_stb_d;
      commit_bcd_q <= commit_bcd_d;
      commit_len_q <= commit_len_d;
      key_error_q  <= key_error_d;
    end
  end

  assign entry_bcd_o   = entry_q;
  assign digit_count_o = count_q;
  assign digit_stb_o   = digit_stb_q;
  assign digit_val_o   = digit_val_q;
  assign commit_stb_o  = commit_stb_q;
  assign commit_bcd_o  = commit_bcd_q;
  assign commit_len_o  = commit_len_q;
  assign key_error_o   = key_error_q;

endmodule

// File: tb/tb_scan_digit_entry.sv
// Directed bench for scan_digit_entry (NUM_DIGITS=4, numpad enabled).
module tb_scan_digit_entry;

  logic        clk;
  logic        rst_n;
  logic [7:0]  scan_code;
  logic        scan_valid;
  logic [15:0] entry_bcd;
  logic [3:0]  digit_count;
  logic        digit_stb;
  logic [3:0]  digit_val;
  logic        commit_stb;
  logic [15:0] commit_bcd;
  logic [3:0]  commit_len;
  logic        key_error;

  int errors = 0;
  int checks = 0;

  scan_digit_entry #(.NUM_DIGITS(4), .NUMPAD_EN(1), .CNT_W(4)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .scan_code_i   (scan_code),
    .scan_valid_i  (scan_valid),
    .entry_bcd_o   (entry_bcd),
    .digit_count_o (digit_count),
    .digit_stb_o   (digit_stb),
    .digit_val_o   (digit_val),
    .commit_stb_o  (commit_stb),
    .commit_bcd_o  (commit_bcd),
    .commit_len_o  (commit_len),
    .key_error_o   (key_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte for exactly one clock; outputs are sampled 1 time unit after the edge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    scan_code  = b;
    scan_valid = 1'b1;
    @(posedge clk);
    #1;
    scan_valid = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic [15:0] e_bcd, input logic [3:0] e_cnt,
                           input logic e_dstb, input logic e_kerr);
    chk({tag, ".entry"}, 32'(entry_bcd), 32'(e_bcd));
    chk({tag, ".count"}, 32'(digit_count), 32'(e_cnt));
    chk({tag, ".dstb"},  32'(digit_stb), 32'(e_dstb));
    chk({tag, ".kerr"},  32'(key_error), 32'(e_kerr));
  endtask

  initial begin
    rst_n      = 1'b0;
    scan_code  = 8'h00;
    scan_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_state("rst", 16'h0000, 4'd0, 1'b0, 1'b0);
    chk("rst.dval",  32'(digit_val), 32'h0);
    chk("rst.cstb",  32'(commit_stb), 32'h0);
    chk("rst.cbcd",  32'(commit_bcd), 32'h0);
    chk("rst.clen",  32'(commit_len), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Three digits accumulate newest-in-low-nibble.
    send(8'h16); chk_state("t1a", 16'h0001, 4'd1, 1'b1, 1'b0); chk("t1a.val", 32'(digit_val), 32'd1);
    send(8'h1E); chk_state("t1b", 16'h0012, 4'd2, 1'b1, 1'b0); chk("t1b.val", 32'(digit_val), 32'd2);
    send(8'h26); chk_state("t1c", 16'h0123, 4'd3, 1'b1, 1'b0); chk("t1c.val", 32'(digit_val), 32'd3);
    @(posedge clk); #1;
    chk("t1.stb_one_cycle", 32'(digit_stb), 32'h0);
    chk("t1.val_held", 32'(digit_val), 32'd3);

    // Fill to capacity, then overflow.
    send(8'h25); chk_state("t2a", 16'h1234, 4'd4, 1'b1, 1'b0);
    send(8'h2E); chk_state("t2b", 16'h1234, 4'd4, 1'b0, 1'b1); chk("t2b.val", 32'(digit_val), 32'd4);
    @(posedge clk); #1;
    chk("t2.kerr_one_cycle", 32'(key_error), 32'h0);
    send(8'h76); chk_state("esc", 16'h0000, 4'd0, 1'b0, 1'b0);

    // Release sequence discards the released key.
    send(8'h16); chk_state("t3a", 16'h0001, 4'd1, 1'b1, 1'b0);
    send(8'hF0); chk_state("t3b", 16'h0001, 4'd1, 1'b0, 1'b0);
    send(8'h16); chk_state("t3c", 16'h0001, 4'd1, 1'b0, 1'b0);
    send(8'h1E); chk_state("t3d", 16'h0012, 4'd2, 1'b1, 1'b0);
    send(8'h76);

    // Backspace then commit.
    send(8'h36); chk_state("t4a", 16'h0006, 4'd1, 1'b1, 1'b0);
    send(8'h3D); chk_state("t4b", 16'h0067, 4'd2, 1'b1, 1'b0);
    send(8'h66); chk_state("t4c", 16'h0006, 4'd1, 1'b0, 1'b0);
    send(8'h5A); chk_state("t4d", 16'h0000, 4'd0, 1'b0, 1'b0);
    chk("t4d.cstb", 32'(commit_stb), 32'h1);
    chk("t4d.cbcd", 32'(commit_bcd), 32'h6);
    chk("t4d.clen", 32'(commit_len), 32'd1);
    @(posedge clk); #1;
    chk("t4.cstb_one_cycle", 32'(commit_stb), 32'h0);

    // Enter on empty buffer is ignored; keypad Enter commits.
    send(8'h5A); chk_state("t5a", 16'h0000, 4'd0, 1'b0, 1'b0);
    chk("t5a.cstb", 32'(commit_stb), 32'h0);
    chk("t5a.cbcd_held", 32'(commit_bcd), 32'h6);
    send(8'h3E); chk_state("t5b", 16'h0008, 4'd1, 1'b1, 1'b0);
    send(8'hE0); chk("t5c.cstb", 32'(commit_stb), 32'h0);
    send(8'h5A); chk_state("t5d", 16'h0000, 4'd0, 1'b0, 1'b0);
    chk("t5d.cstb", 32'(commit_stb), 32'h1);
    chk("t5d.cbcd", 32'(commit_bcd), 32'h8);
    chk("t5d.clen", 32'(commit_len), 32'd1);

    // Numpad digits; extended non-Enter byte is ignored.
    send(8'h69); chk_state("np1", 16'h0001, 4'd1, 1'b1, 1'b0);
    send(8'h7A); chk_state("np3", 16'h0013, 4'd2, 1'b1, 1'b0);
    send(8'h75); chk_state("np8", 16'h0138, 4'd3, 1'b1, 1'b0);
    send(8'hE0);
    send(8'h70); chk_state("ext_ign", 16'h0138, 4'd3, 1'b0, 1'b0);
    send(8'h76);
    send(8'h66); chk_state("bksp_empty", 16'h0000, 4'd0, 1'b0, 1'b0);

    // Back-to-back bytes (typematic repeat).
    @(negedge clk);
    scan_code = 8'h16; scan_valid = 1'b1;
    @(posedge clk); #1;
    chk_state("b2b1", 16'h0001, 4'd1, 1'b1, 1'b0);
    @(negedge clk);
    scan_code = 8'h16;
    @(posedge clk); #1;
    scan_valid = 1'b0;
    chk_state("b2b2", 16'h0011, 4'd2, 1'b1, 1'b0);
    send(8'h76);

    // Full extended release E0,F0,xx then digit 0.
    send(8'hE0); send(8'hF0); send(8'h70);
    chk_state("extrel", 16'h0000, 4'd0, 1'b0, 1'b0);
    send(8'h45); chk_state("zero", 16'h0000, 4'd1, 1'b1, 1'b0); chk("zero.val", 32'(digit_val), 32'd0);
    send(8'h76);

    // Unknown code, then reset mid-release.
    send(8'h1C); chk_state("t6a", 16'h0000, 4'd0, 1'b0, 1'b1);
    send(8'h3E);
    send(8'hF0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_state("t6rst", 16'h0000, 4'd0, 1'b0, 1'b0);
    chk("t6rst.dval", 32'(digit_val), 32'h0);
    chk("t6rst.cbcd", 32'(commit_bcd), 32'h0);
    chk("t6rst.clen", 32'(commit_len), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h45); chk_state("t6b", 16'h0000, 4'd1, 1'b1, 1'b0); chk("t6b.val", 32'(digit_val), 32'd0);
    send(8'h46); chk_state("t6c", 16'h0009, 4'd2, 1'b1, 1'b0); chk("t6c.val", 32'(digit_val), 32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
